// File: rtl/fifo_flex.sv
// fifo_flex: single-clock FIFO with selectable registered-read or
// first-word fall-through output, occupancy count, programmable
// almost-full/almost-empty flags, synchronous flush and sticky
// overflow/underflow flags.
module fifo_flex #(
   parameter int DATA_WIDTH         = 8,
   parameter int FIFO_ASIZE         = 4,
   parameter int FWFT               = 0,
   parameter int ALMOST_FULL_LEVEL  = 12,
   parameter int ALMOST_EMPTY_LEVEL = 2
) (
   input  logic                  in_clock,
   input  logic                  in_reset_n,
   input  logic                  in_put,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_take,
   input  logic                  in_flush,
   input  logic                  in_clear_errors,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  out_empty,
   output logic                  out_full,
   output logic                  out_almost_empty,
   output logic                  out_almost_full,
   output logic [FIFO_ASIZE:0]   out_count,
   output logic                  out_overflow,
   output logic                  out_underflow
);

   localparam int DEPTH = 1 << FIFO_ASIZE;
   localparam logic [FIFO_ASIZE:0] AF_LVL = ALMOST_FULL_LEVEL[FIFO_ASIZE:0];
   localparam logic [FIFO_ASIZE:0] AE_LVL = ALMOST_EMPTY_LEVEL[FIFO_ASIZE:0];

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [FIFO_ASIZE:0]   wr_ptr_q, wr_ptr_d;
   logic [FIFO_ASIZE:0]   rd_ptr_q, rd_ptr_d;
   logic [FIFO_ASIZE:0]   count_q, count_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  valid_q, valid_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;

   logic [FIFO_ASIZE-1:0] wr_addr, rd_addr;
   logic [DATA_WIDTH-1:0] head_word;
   logic                  empty, full;
   logic                  take_ok, put_ok, take_rej, put_rej;

   assign wr_addr   = wr_ptr_q[FIFO_ASIZE-1:0];
   assign rd_addr   = rd_ptr_q[FIFO_ASIZE-1:0];
   assign head_word = mem_q[rd_addr];

   // Occupancy status decoded from the pointers: the wrap bit tells a full
   // FIFO apart from an empty one when the addresses coincide.
   always_comb begin
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_addr == rd_addr) && (wr_ptr_q[FIFO_ASIZE] != rd_ptr_q[FIFO_ASIZE]);
   end

   // Accept/reject decisions; flush suppresses both transfers and any error.
   always_comb begin
      take_ok  = in_take & ~empty & ~in_flush;
      put_ok   = in_put & (~full | take_ok) & ~in_flush;
      take_rej = in_take & ~take_ok & ~in_flush;
      put_rej  = in_put & ~put_ok & ~in_flush;
   end

   // Next-state for pointers, count, read data and sticky error flags.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      rdata_d  = rdata_q;
      valid_d  = 1'b0;
      ovf_d    = (in_clear_errors ? 1'b0 : ovf_q) | put_rej;
      udf_d    = (in_clear_errors ? 1'b0 : udf_q) | take_rej;

      if (in_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (put_ok)  wr_ptr_d = wr_ptr_q + 1'b1;
         if (take_ok) rd_ptr_d = rd_ptr_q + 1'b1;
         if (put_ok && !take_ok)      count_d = count_q + 1'b1;
         else if (take_ok && !put_ok) count_d = count_q - 1'b1;
      end

      if (FWFT != 0) begin
         // Track the presented head so it stays visible once the FIFO drains.
         if (!empty) rdata_d = head_word;
      end else begin
         if (take_ok) rdata_d = head_word;
         valid_d = take_ok;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge in_clock or negedge in_reset_n) begin
      if (!in_reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rdata_q  <= rdata_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage array; contents are left undefined by reset.
   always_ff @(posedge in_clock) begin
      if (put_ok) mem_q[wr_addr] <= in_data;
   end

   // Output decode from registered state only.
   always_comb begin
      out_empty        = empty;
      out_full         = full;
      out_count        = count_q;
      out_almost_empty = (count_q <= AE_LVL);
      out_almost_full  = (count_q >= AF_LVL);
      out_overflow     = ovf_q;
      out_underflow    = udf_q;
      if (FWFT != 0) begin
         out_valid = ~empty;
         out_data  = empty ? rdata_q : head_word;
      end else begin
         out_valid = valid_q;
         out_data  = rdata_q;
      end
   end

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: one STD and one FWFT instance share stimulus.
// A queue model predicts contents/flags; STD read data flows through an
// expected-response queue that a monitor drains when out_valid appears.
module tb_fifo_flex;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       put = 1'b0, take = 1'b0, flush = 1'b0, clr = 1'b0;
   logic [7:0] din = 8'h00;

   logic [7:0] d_s, d_f;
   logic       v_s, e_s, f_s, ae_s, af_s, ov_s, ud_s;
   logic       v_f, e_f, f_f, ae_f, af_f, ov_f, ud_f;
   logic [4:0] c_s, c_f;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   fifo_flex #(.DATA_WIDTH(8), .FIFO_ASIZE(4), .FWFT(0),
               .ALMOST_FULL_LEVEL(12), .ALMOST_EMPTY_LEVEL(2)) dut_std (
      .in_clock(clk), .in_reset_n(rst_n), .in_put(put), .in_data(din),
      .in_take(take), .in_flush(flush), .in_clear_errors(clr),
      .out_data(d_s), .out_valid(v_s), .out_empty(e_s), .out_full(f_s),
      .out_almost_empty(ae_s), .out_almost_full(af_s), .out_count(c_s),
      .out_overflow(ov_s), .out_underflow(ud_s));

   fifo_flex #(.DATA_WIDTH(8), .FIFO_ASIZE(4), .FWFT(1),
               .ALMOST_FULL_LEVEL(12), .ALMOST_EMPTY_LEVEL(2)) dut_fwft (
      .in_clock(clk), .in_reset_n(rst_n), .in_put(put), .in_data(din),
      .in_take(take), .in_flush(flush), .in_clear_errors(clr),
      .out_data(d_f), .out_valid(v_f), .out_empty(e_f), .out_full(f_f),
      .out_almost_empty(ae_f), .out_almost_full(af_f), .out_count(c_f),
      .out_overflow(ov_f), .out_underflow(ud_f));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model
   logic [7:0] mq[$];
   logic [7:0] exp_q[$];
   logic       m_ovf = 1'b0, m_udf = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         exp_q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         logic t_ok, p_ok;
         t_ok = take && !flush && (mq.size() != 0);
         p_ok = put && !flush && ((mq.size() < 16) || t_ok);
         if (clr) begin m_ovf = 1'b0; m_udf = 1'b0; end
         if (put && !flush && !p_ok) m_ovf = 1'b1;
         if (take && !flush && !t_ok) m_udf = 1'b1;
         if (flush) mq.delete();
         if (t_ok) exp_q.push_back(mq.pop_front());
         if (p_ok) mq.push_back(din);
      end
   end

   // Monitor: flags against the model, STD data against the expected queue,
   // FWFT presented word against the model head.
   always @(negedge clk) begin
      int n;
      n = mq.size();
      chk("count_std", c_s, n);
      chk("count_fwft", c_f, n);
      chk("empty", e_s, n == 0);
      chk("full", f_s, n == 16);
      chk("almost_empty", ae_s, n <= 2);
      chk("almost_full", af_s, n >= 12);
      chk("overflow", ov_s, m_ovf);
      chk("underflow", ud_f, m_udf);
      if (v_s) begin
         if (exp_q.size() == 0) chk("std_unexpected_valid", v_s, 1'b0);
         else chk("std_data", d_s, exp_q.pop_front());
      end else if (exp_q.size() != 0) begin
         chk("std_missing_valid", v_s, 1'b1);
         exp_q.delete();
      end
      chk("fwft_valid", v_f, n != 0);
      if (n != 0) chk("fwft_head", d_f, mq[0]);
   end

   // One clock: inputs applied at a falling edge, held across the rising edge.
   task automatic cyc(input logic p, input logic [7:0] d, input logic t,
                      input logic f, input logic c);
      put = p; din = d; take = t; flush = f; clr = c;
      @(negedge clk);
      put = 1'b0; take = 1'b0; flush = 1'b0; clr = 1'b0;
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #3;
      chk("rst_count", c_s, 0);
      chk("rst_empty", e_s, 1);
      chk("rst_full", f_s, 0);
      chk("rst_ae", ae_s, 1);
      chk("rst_af", af_s, 0);
      chk("rst_data", d_s, 8'h00);
      chk("rst_valid", v_s, 0);
      chk("rst_errs", {ov_s, ud_s}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Fill to full, then one rejected put.
      for (int k = 1; k <= 16; k++) begin
         cyc(1, 8'h10 | 8'(k & 15), 0, 0, 0);
         chk("af_during_fill", af_s, k >= 12);
      end
      chk("fill_full", f_s, 1);
      chk("fill_count", c_s, 16);
      cyc(1, 8'h99, 0, 0, 0);
      chk("ovf_set", ov_s, 1);
      chk("ovf_count", c_s, 16);
      cyc(0, 0, 0, 0, 1);
      chk("ovf_cleared", ov_s, 0);

      // Full with simultaneous put/take.
      cyc(1, 8'h77, 1, 0, 0);
      chk("full_pt_count", c_s, 16);
      chk("full_pt_nooverflow", ov_s, 0);
      chk("full_pt_first", d_s, 8'h11);
      for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 0);
      chk("drain_last_77", d_s, 8'h77);
      chk("drain_empty", e_s, 1);

      // STD read latency and underflow.
      cyc(1, 8'hA5, 0, 0, 0);
      chk("fwft_a5_no_take", d_f, 8'hA5);
      cyc(0, 0, 1, 0, 0);
      chk("std_a5_valid", v_s, 1);
      chk("std_a5_data", d_s, 8'hA5);
      cyc(0, 0, 0, 0, 0);
      chk("std_valid_one_cycle", v_s, 0);
      cyc(0, 0, 1, 0, 0);
      chk("udf_set", ud_s, 1);
      chk("udf_data_kept", d_s, 8'hA5);
      cyc(0, 0, 0, 0, 1);

      // FWFT presentation and pop.
      cyc(1, 8'h3C, 0, 0, 0);
      chk("fwft_3c_valid", v_f, 1);
      chk("fwft_3c_data", d_f, 8'h3C);
      cyc(0, 0, 1, 0, 0);
      chk("fwft_3c_empty", e_f, 1);
      chk("fwft_3c_hold", d_f, 8'h3C);

      // Put on empty with take: put accepted, take rejected.
      cyc(1, 8'h5A, 1, 0, 0);
      chk("pe_count", c_s, 1);
      chk("pe_udf", ud_s, 1);
      cyc(0, 0, 1, 0, 1);
      chk("pe_read", d_s, 8'h5A);
      chk("pe_clr", ud_s, 0);

      // Interleaved traffic wrapping the pointers.
      for (int i = 0; i < 40; i++)
         cyc(i < 36, 8'h40 + 8'(i), (i % 3 != 0) || (i >= 20), 0, 0);
      for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1);

      // Flush with put+take at count=5.
      for (int i = 0; i < 5; i++) cyc(1, 8'hC0 + 8'(i), 0, 0, 0);
      chk("pre_flush_count", c_s, 5);
      cyc(1, 8'hEE, 1, 1, 0);
      chk("flush_count", c_s, 0);
      chk("flush_empty", e_s, 1);
      chk("flush_errs", {ov_s, ud_s}, 2'b00);
      chk("flush_std_valid", v_s, 0);

      // Asynchronous reset in the middle of a burst.
      for (int i = 0; i < 4; i++) cyc(1, 8'hD0 + 8'(i), 0, 0, 0);
      put = 1'b1; din = 8'hDF; take = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count", c_s, 0);
      chk("arst_empty", e_f, 1);
      chk("arst_fwft_valid", v_f, 0);
      chk("arst_std_valid", v_s, 0);
      chk("arst_data", {d_s, d_f}, 16'h0000);
      chk("arst_af", af_s, 0);
      put = 1'b0; take = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
